// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer.
// It owns the program counter, fetches 16-bit instructions over a valid
// handshake and decodes them. It then steps an explicit FSM that drives
// register-write, stack and writeback controls.
// Every output comes straight from a flop.
module ctrl_seq #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8,
   parameter int RET_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              instr_req,
   output logic [PC_W-1:0]   instr_addr,
   input  logic              instr_valid,
   input  logic [15:0]       instr_data,
   input  logic              flag_zero,
   input  logic              stack_full,
   input  logic              stack_empty,
   output logic [3:0]        opcode,
   output logic [3:0]        reg1,
   output logic [3:0]        reg2,
   output logic [3:0]        reg3,
   output logic [DATA_W-1:0] imm_small,
   output logic [DATA_W-1:0] imm_wide,
   output logic              mux_ctrl,
   output logic [1:0]        wb_sel,
   output logic              stack_in_ctrl,
   output logic              reg_we,
   output logic              stack_push,
   output logic              stack_pop,
   output logic              halted,
   output logic              fault,
   output logic [RET_W-1:0]  retired
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALT   = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   localparam logic [3:0] OP_JMP   = 4'h8;
   localparam logic [3:0] OP_JZ    = 4'h9;
   localparam logic [3:0] OP_JNZ   = 4'hA;
   localparam logic [3:0] OP_SET   = 4'hB;
   localparam logic [3:0] OP_HLT   = 4'hC;
   localparam logic [3:0] OP_PUSHR = 4'hD;
   localparam logic [3:0] OP_PUSHI = 4'hE;
   localparam logic [3:0] OP_POP   = 4'hF;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [RET_W-1:0]    retired_q, retired_d;
   logic [3:0]          opcode_q, opcode_d;
   logic [3:0]          reg1_q, reg1_d;
   logic [3:0]          reg2_q, reg2_d;
   logic [3:0]          reg3_q, reg3_d;
   logic [DATA_W-1:0]   imm_small_q, imm_small_d;
   logic [DATA_W-1:0]   imm_wide_q, imm_wide_d;
   logic                mux_ctrl_q, mux_ctrl_d;
   logic [1:0]          wb_sel_q, wb_sel_d;
   logic                stack_in_ctrl_q, stack_in_ctrl_d;
   logic                instr_req_q, instr_req_d;
   logic                reg_we_q, reg_we_d;
   logic                stack_push_q, stack_push_d;
   logic                stack_pop_q, stack_pop_d;
   logic                halted_q, halted_d;
   logic                fault_q, fault_d;

   logic [PC_W-1:0]     pc_inc_s;
   logic [PC_W-1:0]     jump_target_s;
   logic [RET_W-1:0]    retired_inc_s;

   assign pc_inc_s      = pc_q + PC_W'(1);
   assign jump_target_s = PC_W'({reg2_q, reg3_q});
   assign retired_inc_s = retired_q + RET_W'(1);

   // Next-state and next-output logic for the sequencer FSM.
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      retired_d       = retired_q;
      opcode_d        = opcode_q;
      reg1_d          = reg1_q;
      reg2_d          = reg2_q;
      reg3_d          = reg3_q;
      imm_small_d     = imm_small_q;
      imm_wide_d      = imm_wide_q;
      mux_ctrl_d      = mux_ctrl_q;
      wb_sel_d        = wb_sel_q;
      stack_in_ctrl_d = stack_in_ctrl_q;
      reg_we_d        = 1'b0;
      stack_push_d    = 1'b0;
      stack_pop_d     = 1'b0;

      case (state_q)
         ST_FETCH: begin
            // The request flop must already be high: this gives the
            // one-clock re-request after reset release.
            if (instr_req_q && instr_valid) begin
               opcode_d        = instr_data[15:12];
               reg1_d          = instr_data[11:8];
               reg2_d          = instr_data[7:4];
               reg3_d          = instr_data[3:0];
               imm_small_d     = DATA_W'(instr_data[3:0]);
               imm_wide_d      = DATA_W'(instr_data[7:0]);
               mux_ctrl_d      = ~instr_data[15] & instr_data[14];
               stack_in_ctrl_d = (instr_data[15:12] == OP_PUSHI);
               if (instr_data[15:12] == OP_SET) begin
                  wb_sel_d = 2'b01;
               end else if (instr_data[15:12] == OP_POP) begin
                  wb_sel_d = 2'b10;
               end else begin
                  wb_sel_d = 2'b00;
               end
               state_d = ST_DECODE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: begin
            // Stack status is sampled here so that the strobe is high
            // throughout EXEC. EXEC then branches on the strobe itself,
            // so the strobe and the fault decision always agree.
            if (opcode_q == OP_PUSHR || opcode_q == OP_PUSHI) begin
               stack_push_d = ~stack_full;
            end else if (opcode_q == OP_POP) begin
               stack_pop_d = ~stack_empty;
            end else begin
               stack_push_d = 1'b0;
            end
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (opcode_q)
               OP_JMP: begin
                  pc_d      = jump_target_s;
                  retired_d = retired_inc_s;
                  state_d   = ST_FETCH;
               end
               OP_JZ: begin
                  pc_d      = flag_zero ? jump_target_s : pc_inc_s;
                  retired_d = retired_inc_s;
                  state_d   = ST_FETCH;
               end
               OP_JNZ: begin
                  pc_d      = flag_zero ? pc_inc_s : jump_target_s;
                  retired_d = retired_inc_s;
                  state_d   = ST_FETCH;
               end
               OP_HLT: begin
                  state_d = ST_HALT;
               end
               OP_PUSHR, OP_PUSHI: begin
                  if (stack_push_q) begin
                     pc_d      = pc_inc_s;
                     retired_d = retired_inc_s;
                     state_d   = ST_FETCH;
                  end else begin
                     state_d = ST_FAULT;
                  end
               end
               OP_POP: begin
                  if (stack_pop_q) begin
                     reg_we_d = 1'b1;
                     state_d  = ST_WB;
                  end else begin
                     state_d = ST_FAULT;
                  end
               end
               default: begin
                  // ALU ops 0x0-0x7 and SET write back.
                  reg_we_d = 1'b1;
                  state_d  = ST_WB;
               end
            endcase
         end
         ST_WB: begin
            pc_d      = pc_inc_s;
            retired_d = retired_inc_s;
            state_d   = ST_FETCH;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase

      instr_req_d = (state_d == ST_FETCH);
      halted_d    = (state_d == ST_HALT);
      fault_d     = (state_d == ST_FAULT);
   end

   // State and registered outputs; async reset clears everything to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_FETCH;
         pc_q            <= '0;
         retired_q       <= '0;
         opcode_q        <= 4'h0;
         reg1_q          <= 4'h0;
         reg2_q          <= 4'h0;
         reg3_q          <= 4'h0;
         imm_small_q     <= '0;
         imm_wide_q      <= '0;
         mux_ctrl_q      <= 1'b0;
         wb_sel_q        <= 2'b00;
         stack_in_ctrl_q <= 1'b0;
         instr_req_q     <= 1'b0;
         reg_we_q        <= 1'b0;
         stack_push_q    <= 1'b0;
         stack_pop_q     <= 1'b0;
         halted_q        <= 1'b0;
         fault_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         retired_q       <= retired_d;
         opcode_q        <= opcode_d;
         reg1_q          <= reg1_d;
         reg2_q          <= reg2_d;
         reg3_q          <= reg3_d;
         imm_small_q     <= imm_small_d;
         imm_wide_q      <= imm_wide_d;
         mux_ctrl_q      <= mux_ctrl_d;
         wb_sel_q        <= wb_sel_d;
         stack_in_ctrl_q <= stack_in_ctrl_d;
         instr_req_q     <= instr_req_d;
         reg_we_q        <= reg_we_d;
         stack_push_q    <= stack_push_d;
         stack_pop_q     <= stack_pop_d;
         halted_q        <= halted_d;
         fault_q         <= fault_d;
      end
   end

   assign instr_req     = instr_req_q;
   assign instr_addr    = pc_q;
   assign opcode        = opcode_q;
   assign reg1          = reg1_q;
   assign reg2          = reg2_q;
   assign reg3          = reg3_q;
   assign imm_small     = imm_small_q;
   assign imm_wide      = imm_wide_q;
   assign mux_ctrl      = mux_ctrl_q;
   assign wb_sel        = wb_sel_q;
   assign stack_in_ctrl = stack_in_ctrl_q;
   assign reg_we        = reg_we_q;
   assign stack_push    = stack_push_q;
   assign stack_pop     = stack_pop_q;
   assign halted        = halted_q;
   assign fault         = fault_q;
   assign retired       = retired_q;

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Parametrised multi-cycle control sequencer; next-generation CPU control unit.
- Owns the program counter and fetches 16-bit instructions over a valid handshake.
- Decodes 4-bit opcode plus three 4-bit fields; drives register bank, ALU operand muxes, writeback mux and stack.
- Adds relative to the previous unit: explicit FSM, conditional branches, halt and fault states, stack full/empty checks, retire counter.

Parameters:
- DATA_W, 8, datapath width; must be >= 8.
- PC_W, 8, program counter width.
- RET_W, 16, width of retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_req  output  1  fetch request, held high until accepted.
- instr_addr  output  PC_W  fetch address; equals pc.
- instr_valid  input  1  instr_data valid; accepted only while instr_req=1.
- instr_data  input  16  [15:12] opcode, [11:8] r1, [7:4] r2, [3:0] r3.
- flag_zero  input  1  zero flag from status register.
- stack_full  input  1  stack cannot accept a push.
- stack_empty  input  1  stack has nothing to pop.
- opcode  output  4  latched opcode; also the ALU op.
- reg1, reg2, reg3  output  4 each  latched register fields.
- imm_small  output  DATA_W  zero-extended r3.
- imm_wide  output  DATA_W  zero-extended {r2,r3}.
- mux_ctrl  output  1  opcode[2] for ALU ops 0x0-0x7; 0 otherwise.
- wb_sel  output  2  writeback source: 00 ALU, 01 imm_wide (SET), 10 stack (POP).
- stack_in_ctrl  output  1  1 = push immediate, 0 = push reg1.
- reg_we  output  1  register write pulse.
- stack_push, stack_pop  output  1 each  single-cycle stack strobes.
- halted  output  1  in HALT.
- fault  output  1  in FAULT.
- retired  output  RET_W  count of completed instructions.

Behaviour:
- Reset (async, rst=1) drives all outputs to 0: pc=0, retired=0, opcode/fields=0, strobes=0, halted=0, fault=0. FSM forced to FETCH.
- Releasing reset mid-fetch: instr_req re-asserts on the first clock after release.
- FSM states: FETCH, DECODE, EXEC, WB, HALT, FAULT.
- FETCH:
  - instr_req=1, instr_addr=pc.
  - On a clock with instr_valid=1, latch instr_data and go to DECODE.
  - Otherwise stay; wait cycles are unbounded.
- DECODE (1 cycle): latched fields are visible; mux_ctrl, wb_sel and stack_in_ctrl are set.
- Opcode map:
  - 0x0-0x7: ALU ops; bit2 set selects immediate operand.
  - 0x8: JMP.
  - 0x9: JZ.
  - 0xA: JNZ.
  - 0xB: SET.
  - 0xC: HLT.
  - 0xD: PUSH reg1.
  - 0xE: PUSH immediate.
  - 0xF: POP.
- EXEC (1 cycle):
  - Jumps: if taken, pc <= {r2,r3} truncated or zero-extended to PC_W; else pc <= pc+1. JMP always taken; JZ taken when flag_zero=1; JNZ taken when flag_zero=0. Then FETCH.
  - HLT: pc unchanged; go to HALT.
  - PUSH: if stack_full, go to FAULT with no strobe; else stack_push=1 for this cycle, pc+1, then FETCH.
  - POP: if stack_empty, go to FAULT; else stack_pop=1, then WB.
  - ALU and SET: go to WB.
- WB (1 cycle): reg_we=1 for ALU, SET and POP; pc <= pc+1; then FETCH.
- reg_we is never asserted for opcodes 0x8-0xE.
- retired increments by 1 on the EXEC->FETCH or WB->FETCH transition; wraps modulo 2^RET_W.
- HLT and faulting instructions do not retire.
- pc increment wraps modulo 2^PC_W.
- HALT and FAULT are sticky until rst. instr_req=0, all strobes 0, pc frozen.
- Latency: jump/push = fetch + 2 cycles. ALU/SET/POP = fetch + 3 cycles.
- instr_valid outside FETCH is ignored.
- Strobes (reg_we, stack_push, stack_pop) are 1-cycle pulses, registered, mutually exclusive.

Test Plan:
- Reset, then instr_valid=1 every cycle with 0x0123 (ALU reg op): reg_we pulses on the 4th cycle after reset release; mux_ctrl=0; wb_sel=00; pc=1; retired=1.
- 0xB1A5 (SET r1,0xA5): wb_sel=01, imm_wide=0xA5, reg_we one pulse, pc+1. Then 0x9040 with flag_zero=1: pc=0x40. Repeat with flag_zero=0: pc increments.
- PC wrap: PC_W=8, 0x80FF then JNZ not taken at 0xFF: pc wraps 0xFF->0x00.
- 0xE0C3 with stack_full=0: stack_push single pulse, stack_in_ctrl=1. Then 0xF200 with stack_empty=1: fault=1, no stack_pop, instr_req stays 0, retired unchanged.
- 0xC000: halted=1, pc frozen. instr_valid pulses ignored for 20 cycles. Asserting rst mid-wait in FETCH with instr_valid=0 clears pc, retired, halted and fault asynchronously.
